mem_berger_ctrl: RTL and testbench
==================================

MEM_BERGER_CTRL -- requirements
Module: mem_berger_ctrl

Interface
REQ-001 SHALL have parameter SCRUB_INTERVAL, default 64, meaning the number of IDLE cycles between scrub reads (legal 1..255).
REQ-002 SHALL have ports: clk input 1, clock; rst input 1, reset, asynchronous, active-high.
REQ-003 SHALL have ports for A: req_a in 1, request; we_a in 1, write (1) or read (0); addr_a in 4, word address; wdata_a in 8, write data; gnt_a out 1, grant pulse; rdata_a out 8, read data; rvalid_a out 1, read-data valid pulse; rerr_a out 1, Berger error on the read.
REQ-004 SHALL have ports for B: req_b, we_b, addr_b, wdata_b, gnt_b, rdata_b, rvalid_b, rerr_b, with the same widths and meanings as A.
REQ-005 SHALL have memory ports: mem_wr_en out 1, write strobe; mem_addr out 4, address; mem_wdata out 12, encoded word; mem_rdata in 12, combinational read word.
REQ-006 SHALL have status ports: err_clr in 1, clear error status; err_flag out 1, sticky error seen; err_addr out 4, first error address; err_cnt out 8, saturating error count; scrub_done out 1, pulse after address 15 is scrubbed.

Function
REQ-007 Word layout SHALL be {data[7:0], check[3:0]}, where check = popcount(data) (0..8) and mem_wdata = {wdata, popcount(wdata)}.
REQ-008 A word SHALL be in error when popcount(word[11:4]) != word[3:0]; an all-zero word is valid.
REQ-009 The FSM SHALL have states IDLE, ACCESS and SCRUB; reset enters IDLE.
REQ-010 IDLE with scrub_pending SHALL go to SCRUB; otherwise, with any req, it SHALL latch the winner's we/addr/wdata and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: a sole requester wins; when both request, the port not served last wins; after reset, A wins the first tie.
REQ-012 ACCESS SHALL drive mem_addr from the latched address, pulse the winner's gnt for exactly this cycle, and return to IDLE.
REQ-013 A write in ACCESS SHALL set mem_wr_en=1 for this cycle only.
REQ-014 A read in ACCESS SHALL register mem_rdata[11:4] into the winner's rdata and the check result into its rerr; rvalid SHALL pulse the next cycle.
REQ-015 rdata SHALL hold its value until the next read on the same port.
REQ-016 Requesters SHALL hold req and the operands stable until gnt; at most one grant SHALL occur per 2 cycles.
REQ-017 mem_wr_en SHALL be 0 in every state except a write ACCESS.
REQ-018 A read error SHALL also update err_flag, err_addr and err_cnt per REQ-021.
REQ-019 The scrub timer SHALL count IDLE cycles and set scrub_pending when it reaches SCRUB_INTERVAL; entering SCRUB SHALL clear the timer and scrub_pending.
REQ-020 SCRUB SHALL read mem_addr = scrub_ptr, check the word, increment scrub_ptr (15 wraps to 0, with scrub_done pulsing the next cycle), and return to IDLE.
REQ-021 On any detected error: err_cnt SHALL increment, saturating at 255; if err_flag=0, err_addr SHALL capture the address; err_flag SHALL set.
REQ-022 err_clr SHALL zero err_flag, err_cnt and err_addr; an error in the same cycle SHALL win (flag=1, cnt=1, addr=new).
REQ-023 Reads SHALL never write back; the code detects errors only.

Reset
REQ-024 rst SHALL asynchronously force: state IDLE; all gnt, rvalid, rerr, mem_wr_en and scrub_done = 0; rdata = 0; err_* = 0; scrub_ptr = 0; timer = 0; scrub_pending = 0; round-robin to favour A.
REQ-025 Reset during ACCESS SHALL abort the operation, with no gnt, rvalid or write after release.

Configuration
REQ-026 With macro BERGER_SCRUB_EN defined, the scrubber (timer, SCRUB state, scrub_ptr) SHALL be present.
REQ-027 Without BERGER_SCRUB_EN, SCRUB SHALL be unreachable, scrub_done SHALL be tied to 0, and errors SHALL be reported from port reads only.

Verification
REQ-028 Write A addr 3 data 0xA5 -> mem_wdata=0xA54, mem_wr_en=1 for one cycle, gnt_a=1 for one cycle.
REQ-029 Read A addr 3 -> rdata_a=0xA5, rerr_a=0, rvalid_a pulses 2 cycles after req is first seen in IDLE.
REQ-030 req_a and req_b held together for 4 grants from reset -> grant order A,B,A,B.
REQ-031 mem_rdata forced to 0xFF3 on a B read of addr 7 -> rerr_b=1, err_flag=1, err_addr=7, err_cnt=1; a later error at addr 9 -> err_addr stays 7, err_cnt=2.
REQ-032 err_clr asserted in the same cycle as an error at addr 5 -> err_flag=1, err_cnt=1, err_addr=5.
REQ-033 BERGER_SCRUB_EN, SCRUB_INTERVAL=1, no requests -> addresses 0..15 scrubbed in order, scrub_done pulses once per wrap, mem_wr_en stays 0.

Source files
------------

// File: rtl/mem_berger_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_berger_ctrl_if
// Request/response bundle between two requesters (A and B) and the
// Berger-coded memory controller.
//   req_x    : request, held with its operands until gnt_x
//   we_x     : 1 = write, 0 = read
//   addr_x   : 4-bit word address
//   wdata_x  : 8-bit write data
//   gnt_x    : one-cycle grant pulse
//   rdata_x  : read data, held until the next read on the same port
//   rvalid_x : one-cycle read-data-valid pulse
//   rerr_x   : Berger check failed on the read
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface mem_berger_ctrl_if;
  logic       req_a;
  logic       we_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a;
  logic       gnt_a;
  logic [7:0] rdata_a;
  logic       rvalid_a;
  logic       rerr_a;

  logic       req_b;
  logic       we_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b;
  logic       gnt_b;
  logic [7:0] rdata_b;
  logic       rvalid_b;
  logic       rerr_b;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, rdata_a, rvalid_a, rerr_a,
    input  gnt_b, rdata_b, rvalid_b, rerr_b
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, rdata_a, rvalid_a, rerr_a,
    output gnt_b, rdata_b, rvalid_b, rerr_b
  );
endinterface

// File: rtl/mem_berger_ctrl.sv
// ---------------------------------------------------------------------------
// mem_berger_ctrl
// Two-port round-robin controller for a 16 x 12-bit external memory whose
// words carry a Berger-style check: {data[7:0], popcount(data)[3:0]}.
// Errors are detected and logged, never corrected or written back.
//
// Optional feature: define BERGER_SCRUB_EN to include the background
// scrubber (IDLE-cycle timer, SCRUB state, scrub pointer). Without it the
// SCRUB state is unreachable and scrub_done is tied low.
//
// Parameter:
//   SCRUB_INTERVAL : IDLE cycles between scrub reads (1..255)
// Ports:
//   clk, rst       : clock; asynchronous active-high reset
//   bus            : requester bundle (slave modport), ports A and B
//   mem_wr_en      : memory write strobe (write ACCESS cycle only)
//   mem_addr       : memory word address
//   mem_wdata      : encoded write word
//   mem_rdata      : combinational read word from the memory
//   err_clr        : clear error status (a same-cycle error wins)
//   err_flag       : sticky "error seen"
//   err_addr       : address of the first error since the last clear
//   err_cnt        : saturating error count
//   scrub_done     : pulse the cycle after address 15 is scrubbed
// ---------------------------------------------------------------------------
module mem_berger_ctrl #(
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_berger_ctrl_if.slave         bus,
  output logic                     mem_wr_en,
  output logic [3:0]               mem_addr,
  output logic [11:0]              mem_wdata,
  input  logic [11:0]              mem_rdata,
  input  logic                     err_clr,
  output logic                     err_flag,
  output logic [3:0]               err_addr,
  output logic [7:0]               err_cnt,
  output logic                     scrub_done
);

  if (SCRUB_INTERVAL < 1 || SCRUB_INTERVAL > 255) begin : g_bad_interval
    $error("mem_berger_ctrl: SCRUB_INTERVAL must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SCRUB  = 2'd2
  } state_e;

  // Port identifiers for winner/last-served tracking.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, d[i]};
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       winner_q, winner_d;    // port served by the current ACCESS
  logic       last_q, last_d;        // port served most recently
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic [7:0] rdata_a_q, rdata_a_d;
  logic [7:0] rdata_b_q, rdata_b_d;
  logic       rerr_a_q, rerr_a_d;
  logic       rerr_b_q, rerr_b_d;
  logic       rvalid_a_q, rvalid_a_d;
  logic       rvalid_b_q, rvalid_b_d;

  logic       err_flag_q, err_flag_d;
  logic [3:0] err_addr_q, err_addr_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Scrubber view shared with the main datapath; constant when compiled out.
  logic       scrub_pending;
  logic [3:0] scrub_ptr;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic       access_rd;   // port read completing this cycle
  logic       scrub_rd;    // scrub read completing this cycle
  logic       word_ok;
  logic       err_hit;
  logic [3:0] err_at;
  logic       pick;
  logic       gnt_a, gnt_b;

  assign access_rd = (state_q == ST_ACCESS) && !we_q;
  assign scrub_rd  = (state_q == ST_SCRUB);
  // All-zero words pass naturally: popcount(0) == 0.
  assign word_ok   = (popcount8(mem_rdata[11:4]) == mem_rdata[3:0]);
  assign err_hit   = (access_rd || scrub_rd) && !word_ok;
  assign err_at    = scrub_rd ? scrub_ptr : addr_q;

  // Round-robin: a sole requester wins; on a tie the port not served last.
  assign pick = (bus.req_a && bus.req_b) ? ~last_q : bus.req_b;

  // ---------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rerr_a_d   = rerr_a_q;
    rerr_b_d   = rerr_b_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = {wdata_q, popcount8(wdata_q)};

    unique case (state_q)
      ST_IDLE: begin
        // A pending scrub takes priority over port requests.
        if (scrub_pending) begin
          state_d = ST_SCRUB;
        end else if (bus.req_a || bus.req_b) begin
          winner_d = pick;
          last_d   = pick;
          we_d     = (pick == PORT_B) ? bus.we_b    : bus.we_a;
          addr_d   = (pick == PORT_B) ? bus.addr_b  : bus.addr_a;
          wdata_d  = (pick == PORT_B) ? bus.wdata_b : bus.wdata_a;
          state_d  = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        gnt_a     = (winner_q == PORT_A);
        gnt_b     = (winner_q == PORT_B);
        mem_wr_en = we_q;
        if (access_rd) begin
          if (winner_q == PORT_B) begin
            rdata_b_d  = mem_rdata[11:4];
            rerr_b_d   = !word_ok;
            rvalid_b_d = 1'b1;
          end else begin
            rdata_a_d  = mem_rdata[11:4];
            rerr_a_d   = !word_ok;
            rvalid_a_d = 1'b1;
          end
        end
        state_d = ST_IDLE;
      end

      ST_SCRUB: begin
        mem_addr = scrub_ptr;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Error log. A new error outranks a simultaneous clear, so the clear
    // and the first error of the new epoch collapse into one update.
    if (err_hit) begin
      if (err_clr) begin
        err_flag_d = 1'b1;
        err_cnt_d  = 8'd1;
        err_addr_d = err_at;
      end else begin
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        if (!err_flag_q) begin
          err_addr_d = err_at;
        end
        err_flag_d = 1'b1;
      end
    end else if (err_clr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = 8'd0;
      err_addr_d = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      winner_q   <= PORT_A;
      last_q     <= PORT_B;   // so that A wins the first tie
      we_q       <= 1'b0;
      addr_q     <= 4'd0;
      wdata_q    <= 8'd0;
      rdata_a_q  <= 8'd0;
      rdata_b_q  <= 8'd0;
      rerr_a_q   <= 1'b0;
      rerr_b_q   <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= 4'd0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rerr_a_q   <= rerr_a_d;
      rerr_b_q   <= rerr_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Background scrubber
  // ---------------------------------------------------------------------
`ifdef BERGER_SCRUB_EN
  localparam logic [7:0] SCRUB_LIMIT = 8'(SCRUB_INTERVAL);

  logic [7:0] timer_q, timer_d;
  logic       pending_q, pending_d;
  logic [3:0] ptr_q, ptr_d;
  logic       done_q, done_d;
  logic [7:0] timer_inc;

  assign timer_inc = timer_q + 8'd1;

  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (pending_q) begin
        // Leaving IDLE for SCRUB this cycle.
        timer_d   = 8'd0;
        pending_d = 1'b0;
      end else begin
        timer_d = timer_inc;
        if (timer_inc == SCRUB_LIMIT) begin
          pending_d = 1'b1;
        end
      end
    end

    if (scrub_rd) begin
      ptr_d  = ptr_q + 4'd1;          // 15 wraps to 0
      done_d = (ptr_q == 4'hF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= 8'd0;
      pending_q <= 1'b0;
      ptr_q     <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
    end
  end

  assign scrub_pending = pending_q;
  assign scrub_ptr     = ptr_q;
  assign scrub_done    = done_q;
`else
  assign scrub_pending = 1'b0;
  assign scrub_ptr     = 4'd0;
  assign scrub_done    = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rerr_a   = rerr_a_q;
  assign bus.rerr_b   = rerr_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mem_berger_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_berger_ctrl
// Directed bench for mem_berger_ctrl with a 16 x 12 memory model.
// Default build: reset, arbitration, write/read, error log, clear,
// saturation and reset-during-access. With BERGER_SCRUB_EN: reset and the
// background scrub walk with SCRUB_INTERVAL = 1.
// ---------------------------------------------------------------------------
module tb_mem_berger_ctrl;

`ifdef BERGER_SCRUB_EN
  localparam int SI = 1;
`else
  localparam int SI = 64;
`endif

  logic        clk;
  logic        rst;
  logic        mem_wr_en;
  logic [3:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        err_clr;
  logic        err_flag;
  logic [3:0]  err_addr;
  logic [7:0]  err_cnt;
  logic        scrub_done;

  mem_berger_ctrl_if bus ();

  mem_berger_ctrl #(.SCRUB_INTERVAL(SI)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err_clr    (err_clr),
    .err_flag   (err_flag),
    .err_addr   (err_addr),
    .err_cnt    (err_cnt),
    .scrub_done (scrub_done)
  );

  // Memory model with an override used to plant corrupted words.
  logic [11:0] mem [16];
  logic        force_en;
  logic [11:0] force_val;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = force_en ? force_val : mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? bus.gnt_b : bus.gnt_a;
  endfunction

  function automatic logic rvalid_of(input bit p);
    return p ? bus.rvalid_b : bus.rvalid_a;
  endfunction

  function automatic logic [7:0] rdata_of(input bit p);
    return p ? bus.rdata_b : bus.rdata_a;
  endfunction

  function automatic logic rerr_of(input bit p);
    return p ? bus.rerr_b : bus.rerr_a;
  endfunction

  task automatic set_req(input bit p, input bit r, input bit we,
                         input logic [3:0] a, input logic [7:0] d);
    if (p) begin
      bus.req_b = r; bus.we_b = we; bus.addr_b = a; bus.wdata_b = d;
    end else begin
      bus.req_a = r; bus.we_a = we; bus.addr_a = a; bus.wdata_a = d;
    end
  endtask

  task automatic check_reset_state();
    check("rst_gnt_a",    32'(bus.gnt_a),    32'h0);
    check("rst_gnt_b",    32'(bus.gnt_b),    32'h0);
    check("rst_rvalid_a", 32'(bus.rvalid_a), 32'h0);
    check("rst_rvalid_b", 32'(bus.rvalid_b), 32'h0);
    check("rst_rerr_a",   32'(bus.rerr_a),   32'h0);
    check("rst_rdata_b",  32'(bus.rdata_b),  32'h0);
    check("rst_wr_en",    32'(mem_wr_en),    32'h0);
    check("rst_err_flag", 32'(err_flag),     32'h0);
    check("rst_err_cnt",  32'(err_cnt),      32'h0);
    check("rst_err_addr", 32'(err_addr),     32'h0);
    check("rst_scrub_done", 32'(scrub_done), 32'h0);
  endtask

`ifndef BERGER_SCRUB_EN
  // Starts at a negedge with the controller in IDLE; grant is due one cycle later.
  task automatic do_write(input bit p, input logic [3:0] a, input logic [7:0] d,
                          input logic [11:0] exp_word, input string tag);
    set_req(p, 1'b1, 1'b1, a, d);
    @(negedge clk);
    check({tag, "_gnt"},       32'(gnt_of(p)),  32'h1);
    check({tag, "_gnt_other"}, 32'(gnt_of(!p)), 32'h0);
    check({tag, "_wr_en"},     32'(mem_wr_en),  32'h1);
    check({tag, "_wdata"},     32'(mem_wdata),  32'(exp_word));
    check({tag, "_addr"},      32'(mem_addr),   32'(a));
    set_req(p, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    check({tag, "_gnt_off"},   32'(gnt_of(p)),  32'h0);
    check({tag, "_wr_off"},    32'(mem_wr_en),  32'h0);
    check({tag, "_stored"},    32'(mem[a]),     32'(exp_word));
  endtask

  task automatic do_read(input bit p, input logic [3:0] a, input logic [7:0] exp_data,
                         input bit exp_err, input bit clr, input string tag);
    set_req(p, 1'b1, 1'b0, a, 8'h00);
    @(negedge clk);
    check({tag, "_gnt"},   32'(gnt_of(p)), 32'h1);
    check({tag, "_wr_en"}, 32'(mem_wr_en), 32'h0);
    check({tag, "_addr"},  32'(mem_addr),  32'(a));
    set_req(p, 1'b0, 1'b0, 4'h0, 8'h00);
    err_clr = clr;
    @(negedge clk);
    err_clr = 1'b0;
    check({tag, "_rvalid"},       32'(rvalid_of(p)),  32'h1);
    check({tag, "_rvalid_other"}, 32'(rvalid_of(!p)), 32'h0);
    check({tag, "_rdata"},        32'(rdata_of(p)),   32'(exp_data));
    check({tag, "_rerr"},         32'(rerr_of(p)),    32'(exp_err));
    @(negedge clk);
    check({tag, "_rvalid_off"},   32'(rvalid_of(p)),  32'h0);
  endtask

  task automatic raw_read(input bit p, input logic [3:0] a);
    bit got;
    got = 1'b0;
    set_req(p, 1'b1, 1'b0, a, 8'h00);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = gnt_of(p);
    end
    set_req(p, 1'b0, 1'b0, 4'h0, 8'h00);
    check("raw_read_gnt", 32'(got), 32'h1);
    @(negedge clk);
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    err_clr = 1'b0;
    force_en = 1'b0;
    force_val = 12'h000;
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
`ifdef BERGER_SCRUB_EN
    // Every word carries data 0 with check 1, so each scrub logs one error.
    for (int i = 0; i < 16; i++) mem[i] = 12'h001;
`else
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
`endif
    repeat (3) @(negedge clk);
    check_reset_state();

`ifndef BERGER_SCRUB_EN
    begin : arb_test
      int grants [4];
      int ng;
      ng = 0;
      for (int k = 0; k < 4; k++) grants[k] = 9;
      rst = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
      set_req(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
      for (int i = 0; i < 16 && ng < 4; i++) begin
        @(negedge clk);
        check("arb_exclusive", 32'(bus.gnt_a & bus.gnt_b), 32'h0);
        if (bus.gnt_a) begin grants[ng] = 0; ng++; end
        else if (bus.gnt_b) begin grants[ng] = 1; ng++; end
      end
      set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      check("arb_count", 32'(ng), 32'h4);
      check("arb_grant0", 32'(grants[0]), 32'h0);
      check("arb_grant1", 32'(grants[1]), 32'h1);
      check("arb_grant2", 32'(grants[2]), 32'h0);
      check("arb_grant3", 32'(grants[3]), 32'h1);
      repeat (2) @(negedge clk);
    end

    do_write(1'b0, 4'h3, 8'hA5, 12'hA54, "wr_a3");
    do_read (1'b0, 4'h3, 8'hA5, 1'b0, 1'b0, "rd_a3");
    do_write(1'b1, 4'h7, 8'h0F, 12'h0F4, "wr_b7");
    do_read (1'b1, 4'h7, 8'h0F, 1'b0, 1'b0, "rd_b7");
    check("clean_err_flag", 32'(err_flag), 32'h0);

    // Corrupted word at B addr 7: popcount(0xFF)=8, stored check 3.
    force_en = 1'b1; force_val = 12'hFF3;
    do_read(1'b1, 4'h7, 8'hFF, 1'b1, 1'b0, "err_b7");
    check("err1_flag", 32'(err_flag), 32'h1);
    check("err1_addr", 32'(err_addr), 32'h7);
    check("err1_cnt",  32'(err_cnt),  32'h1);

    // Second error at A addr 9: data 0 with check 1. First address is kept.
    force_val = 12'h001;
    do_read(1'b0, 4'h9, 8'h00, 1'b1, 1'b0, "err_a9");
    check("err2_addr", 32'(err_addr), 32'h7);
    check("err2_cnt",  32'(err_cnt),  32'h2);
    check("rdata_b_hold", 32'(bus.rdata_b), 32'hFF);
    check("rerr_b_hold",  32'(bus.rerr_b),  32'h1);

    force_en = 1'b0;
    do_read(1'b0, 4'h3, 8'hA5, 1'b0, 1'b0, "rd_a3_again");
    check("clean_cnt_kept", 32'(err_cnt), 32'h2);

    // Clear coinciding with an error at addr 5: the error wins.
    force_en = 1'b1; force_val = 12'hFF3;
    do_read(1'b1, 4'h5, 8'hFF, 1'b1, 1'b1, "clr_err_b5");
    check("clr_err_flag", 32'(err_flag), 32'h1);
    check("clr_err_cnt",  32'(err_cnt),  32'h1);
    check("clr_err_addr", 32'(err_addr), 32'h5);

    // Plain clear.
    force_en = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_flag", 32'(err_flag), 32'h0);
    check("clr_cnt",  32'(err_cnt),  32'h0);
    check("clr_addr", 32'(err_addr), 32'h0);

    // Saturation at 255.
    force_en = 1'b1; force_val = 12'h001;
    for (int i = 0; i < 254; i++) raw_read(1'b0, 4'h2);
    check("sat_cnt_254",  32'(err_cnt),  32'hFE);
    check("sat_addr",     32'(err_addr), 32'h2);
    raw_read(1'b0, 4'h2);
    raw_read(1'b0, 4'h2);
    check("sat_cnt_255",  32'(err_cnt),  32'hFF);
    force_en = 1'b0;

    // Reset in the middle of a write ACCESS aborts it.
    set_req(1'b0, 1'b1, 1'b1, 4'h4, 8'h3C);
    @(negedge clk);
    check("abort_gnt_before", 32'(bus.gnt_a), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_gnt_in_rst", 32'(bus.gnt_a), 32'h0);
    check("abort_wr_in_rst",  32'(mem_wr_en), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_gnt_after",    32'(bus.gnt_a),    32'h0);
      check("abort_rvalid_after", 32'(bus.rvalid_a), 32'h0);
      check("abort_wr_after",     32'(mem_wr_en),    32'h0);
    end
    check("abort_mem_untouched", 32'(mem[4]), 32'h0);
    check("abort_err_cnt",       32'(err_cnt), 32'h0);
`else
    begin : scrub_test
      int scrubs;
      int dones;
      int wr_seen;
      logic [3:0] prev_addr;
      logic [7:0] prev_cnt;
      scrubs = 0; dones = 0; wr_seen = 0;
      prev_cnt = 8'h00;
      rst = 1'b0;
      prev_addr = mem_addr;
      // A scrub is recognised by err_cnt stepping; the address it used is
      // the one sampled one cycle earlier.
      for (int cyc = 0; cyc < 400 && scrubs < 32; cyc++) begin
        @(negedge clk);
        if (err_cnt != prev_cnt) begin
          check($sformatf("scrub_addr_%0d", scrubs), 32'(prev_addr), 32'(scrubs % 16));
          scrubs++;
          prev_cnt = err_cnt;
        end
        if (scrub_done) begin
          dones++;
          check($sformatf("scrub_done_pos_%0d", scrubs), 32'(scrubs % 16), 32'h0);
        end
        if (mem_wr_en) wr_seen++;
        prev_addr = mem_addr;
      end
      check("scrub_count",    32'(scrubs),   32'd32);
      check("scrub_dones",    32'(dones),    32'd2);
      check("scrub_wr_en",    32'(wr_seen),  32'd0);
      check("scrub_err_addr", 32'(err_addr), 32'h0);
      check("scrub_err_flag", 32'(err_flag), 32'h1);
      check("scrub_err_cnt",  32'(err_cnt),  32'd32);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
